// File: rtl/lsu_store_buffer.sv
// Load/store front end: queues stores and drains them into dm as full-word read-modify-writes; loads have one cycle of latency.
// Optional macro LSU_FWD_EN: a load that hits pending stores is forwarded from the buffer instead of stalling.
module lsu_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_memop,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_err,
  output logic        sb_empty,
  output logic        dm_we,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic [1:0]  dm_memop,
  input  logic [31:0] dm_dout
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [6:0]       ent_addr_r [DEPTH];
  logic [3:0]       ent_mask_r [DEPTH];
  logic [31:0]      ent_data_r [DEPTH];
  logic [DEPTH-1:0] ent_valid_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic        full_s;
  logic        mis_s;
  logic        ld_acc_s;
  logic        st_acc_s;
  logic        drain_s;
  logic [3:0]  new_mask_s;
  logic [31:0] new_data_s;
  logic [31:0] ld_word_s;
  logic        unused_s;

  function automatic logic is_misaligned(input logic [1:0] memop, input logic [1:0] lo);
    case (memop)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] memop, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (memop)
      2'b00:   extract = {{24{~uns & b[7]}}, b};
      2'b01:   extract = {{16{~uns & h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  assign unused_s = ^req_addr[31:9];
  assign full_s   = (count_r == FULL_CNT);
  assign sb_empty = (count_r == {(PTR_W+1){1'b0}});
  assign mis_s    = is_misaligned(req_memop, req_addr[1:0]);
  assign ld_acc_s = req_valid & req_ready & ~req_we;
  assign st_acc_s = req_valid & req_ready & req_we & ~mis_s;
  // A load on the port blocks draining for that cycle.
  assign drain_s  = ~ld_acc_s & ~sb_empty;
  assign dm_we    = drain_s;
  assign dm_addr  = ld_acc_s ? req_addr[8:2] : ent_addr_r[head_r];
  assign dm_memop = 2'b10;

`ifdef LSU_FWD_EN
  logic [PTR_W-1:0] fwd_idx_s;

  // Overlay pending bytes of the loaded word onto dm data, oldest entry first.
  always_comb begin
    ld_word_s = dm_dout;
    fwd_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_r + PTR_W'(i);
      for (int k = 0; k < 4; k++) begin
        ld_word_s[8*k +: 8] = (ent_valid_r[fwd_idx_s] && (ent_addr_r[fwd_idx_s] == req_addr[8:2])
                               && ent_mask_r[fwd_idx_s][k]) ? ent_data_r[fwd_idx_s][8*k +: 8]
                                                            : ld_word_s[8*k +: 8];
      end
    end
  end

  // Forwarding makes loads always acceptable.
  always_comb begin
    if (req_we) begin
      req_ready = ~full_s;
    end else begin
      req_ready = 1'b1;
    end
  end
`else
  logic hit_s;

  // Hazard: the load's word still has a pending store.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (ent_valid_r[i] & (ent_addr_r[i] == req_addr[8:2]));
    end
  end

  assign ld_word_s = dm_dout;

  // Loads stall on a hazard unless misaligned; stores wait for a free slot.
  always_comb begin
    if (req_we) begin
      req_ready = ~full_s;
    end else begin
      req_ready = mis_s | ~hit_s;
    end
  end
`endif

  // Build the lane-aligned byte mask and replicated data for a new store.
  always_comb begin
    case (req_memop)
      2'b00: begin
        new_mask_s = 4'b0001 << req_addr[1:0];
        new_data_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        new_mask_s = req_addr[1] ? 4'b1100 : 4'b0011;
        new_data_s = {2{req_wdata[15:0]}};
      end
      default: begin
        new_mask_s = 4'b1111;
        new_data_s = req_wdata;
      end
    endcase
  end

  // Merge the head entry's masked lanes over the current dm word.
  always_comb begin
    dm_din = dm_dout;
    for (int k = 0; k < 4; k++) begin
      dm_din[8*k +: 8] = ent_mask_r[head_r][k] ? ent_data_r[head_r][8*k +: 8] : dm_dout[8*k +: 8];
    end
  end

  // Entry payload; validity is tracked separately so this needs no reset.
  always_ff @(posedge clk) begin
    if (st_acc_s) begin
      ent_addr_r[tail_r] <= req_addr[8:2];
      ent_mask_r[tail_r] <= new_mask_s;
      ent_data_r[tail_r] <= new_data_s;
    end
  end

  // FIFO pointers, occupancy and entry valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {(PTR_W+1){1'b0}};
      ent_valid_r <= {DEPTH{1'b0}};
    end else begin
      if (st_acc_s) begin
        ent_valid_r[tail_r] <= 1'b1;
        tail_r              <= tail_r + PTR_W'(1);
      end
      if (drain_s) begin
        ent_valid_r[head_r] <= 1'b0;
        head_r              <= head_r + PTR_W'(1);
      end
      count_r <= count_r + (PTR_W+1)'(st_acc_s) - (PTR_W+1)'(drain_s);
    end
  end

  // Registered load response and misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0000_0000;
      misalign_err <= 1'b0;
    end else begin
      rsp_valid    <= ld_acc_s;
      misalign_err <= req_valid & req_ready & mis_s;
      if (ld_acc_s) begin
        rsp_rdata <= mis_s ? 32'h0000_0000 : extract(ld_word_s, req_addr[1:0], req_memop, req_unsigned);
      end
    end
  end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Load/store front end sitting directly upstream of the data memory (dm); the MEM stage issues byte/half/word loads and stores to it.
- Stores are queued in a DEPTH-entry FIFO and drained to dm as full-word read-modify-write operations, so byte lanes are correct independent of dm's own lane handling.
- Loads read dm combinationally, extract and extend the addressed byte/half/word, and return the result one cycle later.

Parameters:
- DEPTH, 4, number of store-buffer entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); sizes the FIFO pointers. The occupancy counter is PTR_W+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  MEM-stage request valid.
- req_ready  out  1  request accepted on the cycle where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; only bits [8:0] are used.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_memop  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  out  1  load result valid; registered one-cycle pulse.
- rsp_rdata  out  32  load result, registered.
- misalign_err  out  1  registered one-cycle pulse when a misaligned request is accepted.
- sb_empty  out  1  store buffer holds no entries.
- dm_we  out  1  dm write enable.
- dm_addr  out  7  dm word address [8:2].
- dm_din  out  32  merged word written to dm.
- dm_memop  out  2  driven constant 2'b10 (word).
- dm_dout  in  32  dm combinational read data for dm_addr.

Behaviour:
- Reset:
  - Asserting rst clears all FIFO pointers, the occupancy count and all entry valid bits.
  - rsp_valid=0, rsp_rdata=0, misalign_err=0, sb_empty=1, dm_we=0.
  - Stores pending when reset asserts are lost; reset mid-operation needs no other recovery.
- Entry format: word address [8:2], 4-bit byte mask, 32-bit lane-aligned data.
  - Byte store at lane k: mask = 1<<k; data = {4{wdata[7:0]}}.
  - Half store at addr[1]=h: mask = 0011 or 1100; data = {2{wdata[15:0]}}.
  - Word store: mask = 1111.
- Misalignment:
  - A half with addr[0]=1 is misaligned; a word or memop 11 with addr[1:0]!=0 is misaligned.
  - A misaligned store is accepted and discarded; misalign_err pulses on the next cycle.
  - A misaligned load is accepted; on the next cycle rsp_valid=1, rsp_rdata=0 and misalign_err=1.
- Store accept rule:
  - req_ready = !full when req_we=1.
  - No same-cycle bypass: a full buffer refuses a store even if it drains that cycle.
  - An accepted store is written at the tail on the next clock edge.
- Load accept rule:
  - req_ready = 1 unless the load word address matches any valid entry (hazard).
  - On a hazard the load stalls until the matching entries have drained.
  - Misaligned loads never stall.
- dm port arbitration (combinational):
  - An accepted load owns the port: dm_addr = req_addr[8:2] and dm_we = 0.
  - Otherwise, if the buffer is not empty, the head drains: dm_addr = head address, dm_we = 1.
  - Drain data per lane: dm_din = mask ? entry data : dm_dout.
  - The head pops on that clock edge.
- Storing while draining: a store accepted in the same cycle as a drain is legal; the occupancy count is unchanged.
- Load extraction (registered, latency 1):
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Extension per req_unsigned.
- Ordering:
  - Stores drain in FIFO order, one per cycle when the port is free.
  - A load never observes stale data: either it stalls on a hazard, or its word has no pending store.
- Wrap-around: pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
- sb_empty = (count==0), combinational from the registered count.

Optional Feature:
- Macro: LSU_FWD_EN.
- When defined, a load that hits the buffer does not stall.
  - Result bytes are composed from dm_dout overlaid with every matching entry's masked bytes, applied oldest to youngest.
  - Loads are then always ready; latency stays 1.
- When undefined, loads that hit the buffer stall as described in Behaviour.

Test Plan:
- Reset, then sb on addr 0x05 (wdata 0xAB) over a dm word 0x11223344:
  - After the drain, dm word 1 is 0x1122AB44; sb_empty returns to 1.
- Four stores with DEPTH=4, issued while back-to-back loads block draining:
  - The 5th store sees req_ready=0.
  - After one drain cycle, req_ready=1 again.
- Pending sw 0xDEADBEEF at 0x10, then lw at 0x10:
  - Without LSU_FWD_EN: req_ready=0 until the drain, then rsp_rdata=0xDEADBEEF.
  - With LSU_FWD_EN: no stall, same result.
- lb and lbu at 0x03 with dm word 0x80FFFFFF:
  - lb returns 0xFFFFFF80; lbu returns 0x00000080; rsp_valid arrives one cycle after accept.
- lh at 0x01 and sw at 0x06:
  - Each gives a misalign_err pulse; lh returns rdata 0; dm is unchanged.
- Reset asserted with 3 pending stores:
  - sb_empty=1 immediately, dm_we=0, and no writes reach dm.
